id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 64-bit core, sitting directly upstream of the ALU. Accepts a decoded instruction from decode over a valid/ready handshake, resolves source operands (register file, bypass from EX and MEM, PC/immediate selection) and registers `aluop`, `op1`, `op2` plus writeback control for the execute stage. Detects data hazards that bypassing cannot cover and stalls decode; supports downstream backpressure and synchronous flush.

---
 rtl/id_ex_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 96 +++++++++
 tb/tb_id_ex_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decode -> ID/EX -> execute signal bundle, including the EX/MEM feedback used for bypass.
// slave is the stage's view; master is the view of whatever surrounds it.
interface id_ex_if #(parameter int XLEN = 64);
  logic            id_valid;
  logic            id_ready;
  logic [3:0]      id_aluop;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            id_use_pc;
  logic            id_use_imm;
  logic [4:0]      id_rd_addr;
  logic            id_rd_wen;
  logic            id_is_load;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      mem_rd_addr;
  logic            mem_rd_wen;
  logic [XLEN-1:0] mem_rd_data;
  logic            mem_rd_pending;
  logic            ex_valid;
  logic            ex_ready;
  logic [3:0]      ex_aluop;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_wen;
  logic            ex_is_load;

  modport slave (
    input  id_valid, id_aluop, id_pc, id_imm, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_use_pc,
           id_use_imm, id_rd_addr, id_rd_wen, id_is_load, alu_result,
           mem_rd_addr, mem_rd_wen, mem_rd_data, mem_rd_pending, ex_ready,
    output id_ready, ex_valid, ex_aluop, ex_op1, ex_op2, ex_store_data,
           ex_pc, ex_rd_addr, ex_rd_wen, ex_is_load
  );

  modport master (
    output id_valid, id_aluop, id_pc, id_imm, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_use_pc,
           id_use_imm, id_rd_addr, id_rd_wen, id_is_load, alu_result,
           mem_rd_addr, mem_rd_wen, mem_rd_data, mem_rd_pending, ex_ready,
    input  id_ready, ex_valid, ex_aluop, ex_op1, ex_op2, ex_store_data,
           ex_pc, ex_rd_addr, ex_rd_wen, ex_is_load
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand resolution, hazard stall, backpressure and flush.
// Define ID_EX_FORWARDING_EN to enable the EX/MEM bypass network; otherwise dependents stall to WB.
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  id_ex_if.slave bus
);

  // Handshake: a transfer happens on a rising edge when valid and ready are both high;
  // ready never depends on valid on the same side.
  logic [4:0]      rs_addr [2];
  logic            rs_used [2];
  logic [XLEN-1:0] rs_rf   [2];
  logic [XLEN-1:0] rs_val  [2];
  logic            rs_haz  [2];
  logic            hazard;
  logic            take_in;
  logic            take_out;

  assign rs_addr[0] = bus.id_rs1_addr;
  assign rs_addr[1] = bus.id_rs2_addr;
  assign rs_used[0] = bus.id_rs1_used;
  assign rs_used[1] = bus.id_rs2_used;
  assign rs_rf[0]   = bus.id_rs1_data;
  assign rs_rf[1]   = bus.id_rs2_data;

  always_comb begin
    logic ex_hit;
    logic mem_hit;
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rs_val[i] = rs_rf[i];
      rs_haz[i] = 1'b0;
      ex_hit  = bus.ex_valid && bus.ex_rd_wen && (bus.ex_rd_addr == rs_addr[i]);
      mem_hit = bus.mem_rd_wen && (bus.mem_rd_addr == rs_addr[i]);
      if (rs_addr[i] == 5'd0) begin
        rs_val[i] = '0;
      end else begin
`ifdef ID_EX_FORWARDING_EN
        if (ex_hit && !bus.ex_is_load) begin
          rs_val[i] = bus.alu_result;
        end else if (mem_hit && !bus.mem_rd_pending) begin
          rs_val[i] = bus.mem_rd_data;
        end
        // The youngest writer decides: a usable EX result hides a pending MEM load.
        rs_haz[i] = rs_used[i] && (ex_hit ? bus.ex_is_load : (mem_hit && bus.mem_rd_pending));
`else
        rs_haz[i] = rs_used[i] && (ex_hit || mem_hit);
`endif
      end
    end
  end

`ifndef ID_EX_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{bus.alu_result, bus.mem_rd_data, bus.mem_rd_pending};
`endif

  assign hazard       = rs_haz[0] || rs_haz[1];
  assign bus.id_ready = !flush && !hazard && (!bus.ex_valid || bus.ex_ready);
  assign take_in      = bus.id_valid && bus.id_ready;
  assign take_out     = bus.ex_valid && bus.ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_aluop      <= '0;
      bus.ex_op1        <= '0;
      bus.ex_op2        <= '0;
      bus.ex_store_data <= '0;
      bus.ex_pc         <= '0;
      bus.ex_rd_addr    <= '0;
      bus.ex_rd_wen     <= 1'b0;
      bus.ex_is_load    <= 1'b0;
    end else if (flush) begin
      bus.ex_valid <= 1'b0;
    end else if (take_in) begin
      bus.ex_valid      <= 1'b1;
      bus.ex_aluop      <= bus.id_aluop;
      bus.ex_op1        <= bus.id_use_pc ? bus.id_pc : rs_val[0];
      bus.ex_op2        <= bus.id_use_imm ? bus.id_imm : rs_val[1];
      bus.ex_store_data <= rs_val[1];
      bus.ex_pc         <= bus.id_pc;
      bus.ex_rd_addr    <= bus.id_rd_addr;
      bus.ex_rd_wen     <= bus.id_rd_wen;
      bus.ex_is_load    <= bus.id_is_load;
    end else if (take_out) begin
      bus.ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow whichever ID_EX_FORWARDING_EN build is compiled.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  id_ex_if #(.XLEN(64)) bus ();

  id_ex_stage #(.XLEN(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 1'b0;    bus.id_aluop = '0;       bus.id_pc = '0;
    bus.id_imm = '0;        bus.id_rs1_addr = '0;    bus.id_rs2_addr = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;  bus.id_rs1_data = '0;
    bus.id_rs2_data = '0;   bus.id_use_pc = 1'b0;    bus.id_use_imm = 1'b0;
    bus.id_rd_addr = '0;    bus.id_rd_wen = 1'b0;    bus.id_is_load = 1'b0;
    bus.alu_result = '0;    bus.mem_rd_addr = '0;    bus.mem_rd_wen = 1'b0;
    bus.mem_rd_data = '0;   bus.mem_rd_pending = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [4:0] rs1, input logic u1, input logic [63:0] d1,
                       input logic [4:0] rs2, input logic u2, input logic [63:0] d2,
                       input logic upc, input logic uimm,
                       input logic [4:0] rd, input logic wen, input logic ld);
    bus.id_valid = 1'b1;   bus.id_aluop = op;      bus.id_pc = pc;   bus.id_imm = imm;
    bus.id_rs1_addr = rs1; bus.id_rs1_used = u1;   bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2; bus.id_rs2_used = u2;   bus.id_rs2_data = d2;
    bus.id_use_pc = upc;   bus.id_use_imm = uimm;
    bus.id_rd_addr = rd;   bus.id_rd_wen = wen;    bus.id_is_load = ld;
  endtask

  task automatic drain();
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    bus.id_valid = 1'b1;
    tick();
    tick();
    check("reset_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("reset_ex_op1", bus.ex_op1, 64'd0);
    check("reset_ex_aluop", {60'd0, bus.ex_aluop}, 64'd0);
    check("reset_ex_rd", {59'd0, bus.ex_rd_addr}, 64'd0);
    rst = 1'b0;
    clear_inputs();
    tick();
    check("ready_after_reset", {63'd0, bus.id_ready}, 64'd1);

    // addi x1,x0,5 then add x2,x1,x1
    instr(4'd0, 64'h10, 64'd5, 5'd0, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
    settle();
    check("addi_ready", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("addi_valid", {63'd0, bus.ex_valid}, 64'd1);
    check("addi_op2", bus.ex_op2, 64'd5);
    instr(4'd0, 64'h14, 64'd0, 5'd1, 1'b1, 64'd0, 5'd1, 1'b1, 64'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    bus.alu_result = 64'd5;
`ifdef ID_EX_FORWARDING_EN
    settle();
    check("dep_no_stall", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("dep_op1_fwd", bus.ex_op1, 64'd5);
    check("dep_op2_fwd", bus.ex_op2, 64'd5);
    check("dep_store_fwd", bus.ex_store_data, 64'd5);
`else
    settle();
    check("nf_stall_ex", {63'd0, bus.id_ready}, 64'd0);
    tick();
    check("nf_writer_left", {63'd0, bus.ex_valid}, 64'd0);
    bus.alu_result = 64'hDEAD;
    bus.mem_rd_addr = 5'd1; bus.mem_rd_wen = 1'b1; bus.mem_rd_data = 64'h99;
    settle();
    check("nf_stall_mem", {63'd0, bus.id_ready}, 64'd0);
    tick();
    bus.mem_rd_wen = 1'b0;
    bus.id_rs1_data = 64'd5; bus.id_rs2_data = 64'd5;
    settle();
    check("nf_go_wb", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("nf_op1_rf", bus.ex_op1, 64'd5);
    check("nf_op2_rf", bus.ex_op2, 64'd5);
    check("nf_rd", {59'd0, bus.ex_rd_addr}, 64'd2);
`endif
    drain();

`ifdef ID_EX_FORWARDING_EN
    // ld x3 then add x4,x3,x0
    instr(4'd0, 64'h20, 64'd8, 5'd0, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    check("ld_is_load", {63'd0, bus.ex_is_load}, 64'd1);
    instr(4'd0, 64'h24, 64'd0, 5'd3, 1'b1, 64'hDEAD, 5'd0, 1'b1, 64'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    settle();
    check("lu_stall_ex", {63'd0, bus.id_ready}, 64'd0);
    tick();
    check("lu_bubble", {63'd0, bus.ex_valid}, 64'd0);
    bus.mem_rd_addr = 5'd3; bus.mem_rd_wen = 1'b1; bus.mem_rd_pending = 1'b1; bus.mem_rd_data = 64'h55;
    settle();
    check("lu_stall_pend", {63'd0, bus.id_ready}, 64'd0);
    tick();
    bus.mem_rd_pending = 1'b0; bus.mem_rd_data = 64'h77;
    settle();
    check("lu_go", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("lu_op1", bus.ex_op1, 64'h77);
    check("lu_op2", bus.ex_op2, 64'd0);
    drain();

    // EX writer of x5 masks a pending MEM load of x5
    instr(4'd1, 64'h30, 64'd0, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    instr(4'd1, 64'h34, 64'd0, 5'd0, 1'b0, 64'd0, 5'd5, 1'b1, 64'h1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    bus.alu_result = 64'hA;
    bus.mem_rd_addr = 5'd5; bus.mem_rd_wen = 1'b1; bus.mem_rd_pending = 1'b1;
    settle();
    check("mask_ready", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("mask_op2", bus.ex_op2, 64'hA);
    drain();
`endif

    // writer to x0 in EX, consumer of x0
    instr(4'd2, 64'h40, 64'd0, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    instr(4'd2, 64'h44, 64'd0, 5'd0, 1'b1, 64'h1234, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    bus.alu_result = 64'hFFFF;
    bus.mem_rd_addr = 5'd0; bus.mem_rd_wen = 1'b1; bus.mem_rd_data = 64'hBEEF;
    settle();
    check("x0_ready", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("x0_op1", bus.ex_op1, 64'd0);
    drain();

    // backpressure: A held for 3 cycles while B waits
    instr(4'd3, 64'h100, 64'd8, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    instr(4'd4, 64'h200, 64'd0, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_ready_low", {63'd0, bus.id_ready}, 64'd0);
      tick();
      check("bp_hold_pc", bus.ex_pc, 64'h100);
      check("bp_hold_op", {60'd0, bus.ex_aluop}, 64'd3);
    end
    bus.ex_ready = 1'b1;
    settle();
    check("bp_release", {63'd0, bus.id_ready}, 64'd1);
    tick();
    check("bp_b_pc", bus.ex_pc, 64'h200);
    check("bp_b_op1", bus.ex_op1, 64'h200);
    bus.id_pc = 64'h300;
    tick();
    check("bp_c_pc", bus.ex_pc, 64'h300);
    check("bp_c_valid", {63'd0, bus.ex_valid}, 64'd1);

    // flush with a held instruction and an incoming one
    bus.id_pc = 64'h400;
    flush = 1'b1;
    settle();
    check("flush_ready", {63'd0, bus.id_ready}, 64'd0);
    tick();
    check("flush_valid", {63'd0, bus.ex_valid}, 64'd0);
    flush = 1'b0;
    bus.id_valid = 1'b0;
    tick();
    check("flush_no_accept", {63'd0, bus.ex_valid}, 64'd0);
    check("flush_pc_kept", bus.ex_pc, 64'h300);

    // reset beats flush and a pending transfer
    instr(4'd5, 64'h500, 64'd1, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    check("rst_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("rst_pc", bus.ex_pc, 64'd0);
    rst = 1'b0;
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
